scanline_buffer: RTL and testbench
==================================

SCANLINE_BUFFER -- requirements
Module: scanline_buffer

Interface
REQ-001 Parameter H_RES, default 640, visible pixels per line and depth of each bank.
REQ-002 Parameter CORDW, default 10, x-coordinate width.
REQ-003 Parameter IDX_W, default 8, palette-index width.
REQ-004 clk  input  1  pixel clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 line_start  input  1  one-cycle pulse at each line boundary (sy change); requests bank swap.
REQ-007 fill_done  input  1  one-cycle pulse from the sprite drawer when the next line is fully written.
REQ-008 wr_en  input  1  pixel write strobe into the back bank.
REQ-009 wr_x  input  CORDW  x coordinate of the write.
REQ-010 wr_idx  input  IDX_W  palette index to write; 0 means transparent.
REQ-011 rd_x  input  CORDW  scanout x (sx_next).
REQ-012 de  input  1  data enable for rd_x.
REQ-013 pix_idx  output  IDX_W  registered palette index for the palette read address.
REQ-014 front_sel  output  1  bank currently scanned out (0 = A, 1 = B).
REQ-015 filling  output  1  high while the FSM is in FILL.
REQ-016 underrun  output  1  one-cycle pulse when a swap occurs before fill_done.
REQ-017 wr_dropped  output  1  one-cycle pulse when a write is rejected.

Function
REQ-018 Two banks, A and B, each H_RES x IDX_W RAM, plus one H_RES-bit occupancy bitmap per bank held in flops.
REQ-019 Back bank = !front_sel; writes go only to the back bank; reads come only from the front bank.
REQ-020 FSM states FILL and HOLD; FILL -> HOLD on fill_done; HOLD -> FILL on line_start; FILL -> FILL on line_start.
REQ-021 On every line_start, in either state: front_sel toggles and the new back bank's bitmap clears to all-zero in the same edge.
REQ-022 line_start while in FILL without a simultaneous fill_done: underrun pulses for 1 cycle and the swap still occurs.
REQ-023 line_start and fill_done in the same cycle while in FILL: no underrun; swap occurs; next state is FILL.
REQ-024 A write is accepted only when the state is FILL, wr_en=1, wr_x < H_RES, wr_idx != 0, and the back-bank occupancy bit at wr_x is 0.
REQ-025 An accepted write stores wr_idx at wr_x and sets the occupancy bit; the first accepted write per pixel per line wins.
REQ-026 wr_dropped pulses when wr_en=1 and either the state is HOLD or wr_x >= H_RES.
REQ-027 A transparent write or an occupied-pixel write is silently ignored, with no wr_dropped pulse.
REQ-028 A write coincident with line_start targets the pre-swap back bank (the new front bank), is applied before that bank's bitmap state is frozen, and is subject to REQ-024.
REQ-029 Read latency is 1 cycle: pix_idx(t+1) = front bank data at rd_x(t) if de(t)=1, rd_x(t) < H_RES, and the occupancy bit is 1; otherwise 0.
REQ-030 A read in the cycle of line_start uses the pre-swap front_sel; reads from the next cycle on use the new front bank.
REQ-031 The front bank is never modified while it is front.

Reset
REQ-032 On rst: state = FILL, front_sel = 0, both bitmaps cleared, pix_idx = 0, underrun = 0, wr_dropped = 0, filling = 1.
REQ-033 RAM contents are not cleared by reset; the bitmaps alone guarantee 0 output.
REQ-034 rst asserted mid-line discards all pending writes, and the next cycle behaves as REQ-032.

Verification
REQ-035 Reset, write (x=5, idx=0x2A) to B, fill_done, line_start, de=1 with rd_x=5 -> pix_idx=0x2A one cycle later; rd_x=6 -> 0.
REQ-036 Two writes to x=100 (idx 0x11, then 0x22) in one line, then swap -> pix_idx at x=100 = 0x11; write of idx 0 leaves the pixel at 0.
REQ-037 line_start in FILL with no fill_done -> underrun=1 for exactly 1 cycle, front_sel toggles; line_start coincident with fill_done -> underrun=0.
REQ-038 Write in HOLD, or wr_x=640 -> wr_dropped=1 for 1 cycle, with no change visible after the swap.
REQ-039 Fill a line, swap twice without writes -> the old pixels read 0 (bitmap cleared); de=0 -> pix_idx=0 regardless of content.
REQ-040 Assert rst after writes in FILL, then swap -> all reads return 0, front_sel reads 1 after the first line_start.

Source files
------------

// File: rtl/scanline_buffer.sv
// Double-buffered scanline store: the sprite drawer fills the back bank while
// the front bank is scanned out; line_start swaps banks and clears the new back.
module scanline_buffer #(
   parameter int H_RES = 640,
   parameter int CORDW = 10,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             line_start,
   input  logic             fill_done,
   input  logic             wr_en,
   input  logic [CORDW-1:0] wr_x,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [CORDW-1:0] rd_x,
   input  logic             de,
   output logic [IDX_W-1:0] pix_idx,
   output logic             front_sel,
   output logic             filling,
   output logic             underrun,
   output logic             wr_dropped
);

   typedef enum logic {FILL, HOLD} state_t;

   localparam logic [CORDW:0] X_LIMIT = (CORDW+1)'(H_RES);

   state_t state, state_next;

   logic [IDX_W-1:0] bank_a [H_RES];
   logic [IDX_W-1:0] bank_b [H_RES];
   logic [H_RES-1:0] occ_a, occ_b;

   logic             wr_in_range, rd_in_range;
   logic [CORDW-1:0] wr_addr, rd_addr;
   logic             back_occ, front_occ;
   logic             wr_accept, drop_next, underrun_next;

   // Out-of-range coordinates are folded to 0 so no array is indexed past its end.
   assign wr_in_range = {1'b0, wr_x} < X_LIMIT;
   assign rd_in_range = {1'b0, rd_x} < X_LIMIT;
   assign wr_addr     = wr_in_range ? wr_x : '0;
   assign rd_addr     = rd_in_range ? rd_x : '0;
   assign back_occ    = front_sel ? occ_a[wr_addr] : occ_b[wr_addr];
   assign front_occ   = front_sel ? occ_b[rd_addr] : occ_a[rd_addr];

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_next;
   end

   // A swap always re-enters FILL, even when fill_done arrives in the same cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         FILL: if (!line_start && fill_done) state_next = HOLD;
         HOLD: if (line_start) state_next = FILL;
      endcase
   end

   always_comb begin
      filling       = (state == FILL);
      wr_accept     = filling && wr_en && wr_in_range && (wr_idx != '0) && !back_occ;
      drop_next     = wr_en && (!filling || !wr_in_range);
      underrun_next = filling && line_start && !fill_done;
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_accept) begin
         if (front_sel) bank_a[wr_addr] <= wr_idx;
         else           bank_b[wr_addr] <= wr_idx;
      end
   end

   // The write lands in the outgoing back bank; the clear hits the outgoing front bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_a <= '0;
         occ_b <= '0;
      end else begin
         if (wr_accept) begin
            if (front_sel) occ_a[wr_addr] <= 1'b1;
            else           occ_b[wr_addr] <= 1'b1;
         end
         if (line_start) begin
            if (front_sel) occ_b <= '0;
            else           occ_a <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         front_sel  <= 1'b0;
         pix_idx    <= '0;
         underrun   <= 1'b0;
         wr_dropped <= 1'b0;
      end else begin
         if (line_start) front_sel <= ~front_sel;
         if (de && rd_in_range && front_occ)
            pix_idx <= front_sel ? bank_b[rd_addr] : bank_a[rd_addr];
         else
            pix_idx <= '0;
         underrun   <= underrun_next;
         wr_dropped <= drop_next;
      end
   end

endmodule

// File: tb/tb_scanline_buffer.sv
// Bench for scanline_buffer: a directed vector table for the line-swap corner
// cases, followed by randomized traffic compared against an array-based model.
module tb_scanline_buffer;

   localparam int H_RES = 640;
   localparam int CORDW = 10;
   localparam int IDX_W = 8;

   logic             clk = 1'b0;
   logic             rst, line_start, fill_done, wr_en, de;
   logic [CORDW-1:0] wr_x, rd_x;
   logic [IDX_W-1:0] wr_idx, pix_idx;
   logic             front_sel, filling, underrun, wr_dropped;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit rst, ls, fd, we;
      int wx, widx, rx;
      bit de;
      int pix;
      bit front, fill, under, drop;
   } vec_t;

   vec_t vecs[$];

   // Reference state: one pixel array and one "written this line" array per bank.
   int m_mem [2][H_RES];
   bit m_occ [2][H_RES];
   bit m_front = 1'b0;
   bit m_fill  = 1'b1;
   int e_pix;
   bit e_under, e_drop;

   scanline_buffer #(.H_RES(H_RES), .CORDW(CORDW), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .line_start(line_start), .fill_done(fill_done),
      .wr_en(wr_en), .wr_x(wr_x), .wr_idx(wr_idx), .rd_x(rd_x), .de(de),
      .pix_idx(pix_idx), .front_sel(front_sel), .filling(filling),
      .underrun(underrun), .wr_dropped(wr_dropped)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(bit r, bit ls, bit fd, bit we, int wx, int widx,
                               int rx, bit d, int pix, bit fr, bit fi, bit un, bit dr);
      vec_t v;
      v.rst = r; v.ls = ls; v.fd = fd; v.we = we; v.wx = wx; v.widx = widx;
      v.rx = rx; v.de = d; v.pix = pix; v.front = fr; v.fill = fi;
      v.under = un; v.drop = dr;
      return v;
   endfunction

   task automatic modelStep(input vec_t v);
      int back;
      if (v.rst) begin
         e_pix = 0; e_under = 0; e_drop = 0;
         m_front = 0; m_fill = 1;
         for (int i = 0; i < H_RES; i++) begin
            m_occ[0][i] = 0;
            m_occ[1][i] = 0;
         end
         return;
      end
      e_pix = 0;
      if (v.de && v.rx < H_RES)
         if (m_occ[m_front][v.rx]) e_pix = m_mem[m_front][v.rx];
      e_under = m_fill && v.ls && !v.fd;
      e_drop  = v.we && (!m_fill || v.wx >= H_RES);
      back = m_front ? 0 : 1;
      if (m_fill && v.we && v.wx < H_RES && v.widx != 0)
         if (!m_occ[back][v.wx]) begin
            m_mem[back][v.wx] = v.widx;
            m_occ[back][v.wx] = 1;
         end
      if (v.ls) begin
         for (int i = 0; i < H_RES; i++) m_occ[m_front][i] = 0;
         m_front = ~m_front;
         m_fill  = 1;
      end else if (m_fill && v.fd) begin
         m_fill = 0;
      end
   endtask

   // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
   task automatic applyStimulus(input vec_t v);
      rst        = v.rst;
      line_start = v.ls;
      fill_done  = v.fd;
      wr_en      = v.we;
      wr_x       = CORDW'(v.wx);
      wr_idx     = IDX_W'(v.widx);
      rd_x       = CORDW'(v.rx);
      de         = v.de;
      modelStep(v);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   initial begin
      vec_t v;
      rst = 1; line_start = 0; fill_done = 0; wr_en = 0;
      wr_x = '0; wr_idx = '0; rd_x = '0; de = 0;

      //         rst ls fd we  wx   widx  rx  de  pix   fr fi un dr
      vecs.push_back(mk(1, 0, 0, 0,   0,    0,   0, 0,    0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1,   5, 'h2A,   0, 0,    0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 100, 'h11,   0, 0,    0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 100, 'h22,   0, 0,    0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1,   7,    0,   0, 0,    0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 640, 'h33,   0, 0,    0, 0, 1, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0,   0,    0,   0, 0,    0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1,   9, 'h44,   0, 0,    0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 0,   0,    0,   5, 1,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,   5, 1, 'h2A, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,   6, 1,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0, 100, 1, 'h11, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,   7, 1,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,   9, 1,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,   5, 0,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,   0,    0,   5, 1, 'h2A, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,   5, 1,    0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0,   0,    0,   0, 0,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,   5, 1,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1,  20, 'h55,   0, 0,    0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,  20, 1, 'h55, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1,  30, 'h66,   0, 0,    0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1,  31, 'h77,   0, 0,    0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,   0,    0,   0, 0,    0, 1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,  30, 1,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,  31, 1,    0, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,   0,    0,  20, 1,    0, 1, 1, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d pix_idx", i), int'(pix_idx), vecs[i].pix);
         checkOutput($sformatf("vec%0d front_sel", i), int'(front_sel), int'(vecs[i].front));
         checkOutput($sformatf("vec%0d filling", i), int'(filling), int'(vecs[i].fill));
         checkOutput($sformatf("vec%0d underrun", i), int'(underrun), int'(vecs[i].under));
         checkOutput($sformatf("vec%0d wr_dropped", i), int'(wr_dropped), int'(vecs[i].drop));
      end

      // Narrow x range keeps collisions and re-reads of just-written pixels frequent.
      for (int c = 0; c < 4000; c++) begin
         v.rst  = ($urandom_range(0, 499) == 0);
         v.ls   = ($urandom_range(0, 39) == 0);
         v.fd   = ($urandom_range(0, 29) == 0);
         v.we   = ($urandom_range(0, 2) != 0);
         v.wx   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 1023))
                                              : int'($urandom_range(0, 15));
         v.widx = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
         v.rx   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(640, 1023))
                                               : int'($urandom_range(0, 15));
         v.de   = ($urandom_range(0, 7) != 0);
         applyStimulus(v);
         checkOutput($sformatf("rnd%0d pix_idx", c), int'(pix_idx), e_pix);
         checkOutput($sformatf("rnd%0d front_sel", c), int'(front_sel), int'(m_front));
         checkOutput($sformatf("rnd%0d filling", c), int'(filling), int'(m_fill));
         checkOutput($sformatf("rnd%0d underrun", c), int'(underrun), int'(e_under));
         checkOutput($sformatf("rnd%0d wr_dropped", c), int'(wr_dropped), int'(e_drop));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
